// File: rtl/muldiv_pkg.sv
// Shared encodings and types for the iterative multiply/divide sequencer.
// Imported by muldiv_iter and muldiv_seq.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring divide.
// Purely combinational; the sequencer registers the results.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Divide compares on WIDTH+1 bits: the shifted remainder can
    // exceed WIDTH bits when the divisor has its top bit set.
    always_comb begin
        sum    = {1'b0, acc_hi};
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        diff   = rem_sh[WIDTH-1:0] - operand;
        ge     = rem_sh >= {1'b0, operand};
        nxt_hi = '0;
        nxt_lo = '0;
        if (is_div) begin
            nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            if (acc_lo[0]) begin
                sum = {1'b0, acc_hi} + {1'b0, operand};
            end
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
// busy stalls the controller; done doubles as the HI/LO write enable.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_d,
    input  logic [WIDTH-1:0] rt_d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   rs_q, rt_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0]   it_hi, it_lo;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dz_q;
    logic               neg_p_q, neg_r_q;
    logic [CW-1:0]      cnt_q;

    logic               is_div, is_sgn, by_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes, zero-divisor detect and sign fixups.
    always_comb begin
        is_div   = op_is_div(op_q);
        is_sgn   = op_is_signed(op_q);
        by_zero  = is_div && (rt_q == '0);
        mag_a    = (is_sgn && rs_q[WIDTH-1]) ? -rs_q : rs_q;
        mag_b    = (is_sgn && rt_q[WIDTH-1]) ? -rt_q : rt_q;
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_p_q ? -prod : prod;
        quo_fix  = neg_p_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .is_div  (is_div),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .nxt_hi  (it_hi),
        .nxt_lo  (it_lo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = by_zero ? S_DONE : S_RUN;
            S_RUN:   if (cnt_q == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        rs_q <= rs_d;
                        rt_q <= rt_d;
                        dz_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    neg_p_q  <= is_sgn &
                                (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                    neg_r_q  <= is_sgn & rs_q[WIDTH-1];
                    cnt_q    <= '0;
                    acc_hi_q <= '0;
                    acc_lo_q <= is_div ? mag_a : mag_b;
                    opnd_q   <= is_div ? mag_b : mag_a;
                    if (by_zero) begin
                        hi_q <= rs_q;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_hi_q <= it_hi;
                    acc_lo_q <= it_lo;
                    cnt_q    <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus
// random ops against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_d = '0;
    logic [31:0] rt_d = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] prev_h = '0;
    logic [31:0] prev_l = '0;
    logic        prev_dz = 1'b0;

    muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    task automatic model(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eh,
                         output logic [31:0] el, output logic edz);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        edz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                    edz = 1'b1;
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    el = sq[31:0];
                    eh = sr[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // Issue one op in the next cycle and follow it to done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy);
        logic [31:0] eh, el;
        logic        edz;
        int          exp_cyc, dn;
        bit          busy_bad;
        model(o, a, b, eh, el, edz);
        exp_cyc = edz ? 2 : 35;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_hi", hi, prev_h);
        chk("hold_lo", lo, prev_l);
        start = 1'b1;
        op = o;
        rs_d = a;
        rt_d = b;
        dn = 0;
        busy_bad = 1'b0;
        for (int n = 1; n <= 45 && dn == 0; n++) begin
            @(negedge clk);
            if (!busy) busy_bad = 1'b1;
            if (done) dn = n;
            if (noisy) begin
                start = (n == 5 || n == 20 || n == 34 || n == 35);
                op = 2'($urandom);
                rs_d = $urandom;
                rt_d = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_cycle", 32'(dn), 32'(exp_cyc));
        chk("busy_run", 32'(busy_bad), 32'd0);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("div_zero", 32'(div_zero), 32'(edz));
        prev_h = eh;
        prev_l = el;
        prev_dz = edz;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_min_hi", hi, 32'h4000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        run_op(2'b11, 32'h1234_5678, 32'h8000_0001, 1'b0);

        run_op(2'b01, 32'd1000, 32'd3000, 1'b1);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        chk("dz_set", 32'(div_zero), 32'd1);
        run_op(2'b01, 32'd2, 32'd3, 1'b0);
        chk("dz_clear", 32'(div_zero), 32'd0);

        @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        rs_d = 32'h1234_5678;
        rt_d = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op = 2'b01;
        rs_d = 32'd9;
        rt_d = 32'd9;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        chk("mid_rst_dz", 32'(div_zero), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_ign", 32'(busy), 32'd0);
        prev_h = '0;
        prev_l = '0;
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        chk("divu100_lo", lo, 32'd14);
        chk("divu100_hi", hi, 32'd2);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            if (i % 7 == 3) rb = 32'd0;
            else if (i % 3 == 0) rb = 32'($urandom_range(1, 15));
            else if (i % 4 == 1) rb = 32'hFFFF_FFFF;
            else rb = $urandom;
            run_op(ro, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the multi-cycle CPU. It replaces the single-shot mult/multu/div/divu units with a single radix-2 shift-add / restoring-divide engine. It accepts MULT, MULTU, DIV and DIVU with operands from the register file. It holds busy while running so the controller can stall PC_CLK, then presents HI/LO results with a one-cycle done pulse that serves as HI_W/LO_W.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with start.
- rs_d  in  WIDTH  multiplicand / dividend; latched with start.
- rt_d  in  WIDTH  multiplier / divisor; latched with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; hi/lo valid in the same cycle.
- hi  out  WIDTH  product[63:32] or remainder.
- lo  out  WIDTH  product[31:0] or quotient.
- div_zero  out  1  set at done of a DIV/DIVU with rt=0; cleared at the next accepted start.

## Operation
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- **IDLE**
  - start=1: latch op, rs_d, rt_d; go to PREP.
  - start is ignored in every other state, including DONE.
- **PREP** (1 cycle)
  - Signed ops: take the two's-complement magnitude of each operand. Record neg_p = a[31]^b[31] and neg_r = a[31].
  - Unsigned ops: use the raw operands; both sign flags are 0.
  - Clear the 5-bit iteration counter.
  - DIV/DIVU with rt=0: go directly to DONE with hi=rs_d (latched, raw), lo=32'hFFFF_FFFF, div_zero=1.
  - Otherwise go to RUN.
- **RUN** (exactly WIDTH cycles, counter 0..31)
  - Multiply: 64-bit accumulator {upper, multiplier}. If acc[0]=1, upper += multiplicand (33-bit add, carry kept). Then shift the whole accumulator right by 1, inserting the carry.
  - Divide (restoring): rem = {rem[30:0], q[31]}; q <<= 1. If rem >= divisor, then rem -= divisor and q[0]=1. Compare and subtract are 33-bit.
  - Counter == 31: go to FIX.
- **FIX** (1 cycle)
  - Multiply: if neg_p, negate the 64-bit product.
  - Divide: if neg_p, negate the quotient; if neg_r, negate the remainder.
  - Write the result into the hi/lo output registers.
- **DONE** (1 cycle): done=1; go to IDLE.
- hi, lo and div_zero hold their value after done until the next completion or reset.
- Arithmetic edge cases:
  - 0x8000_0000 / 0xFFFF_FFFF signed gives lo=0x8000_0000, hi=0. This falls out of the unsigned-magnitude path with no special case.
  - MULT of two INT_MIN operands gives hi=0x4000_0000, lo=0.

## Timing
- Start sampled high at edge 0 (state IDLE): PREP in cycle 1, RUN in cycles 2–33, FIX in cycle 34, DONE in cycle 35.
- busy is high in cycles 1–35 and low again from cycle 36, where the next start can be accepted. Throughput is one op per 36 cycles.
- Divide by zero: PREP in cycle 1, DONE in cycle 2, busy high in cycles 1–2.
- busy and done are registered outputs with no combinational path from start.
- Reset at any point, mid-RUN included: at the next edge the block is in IDLE with busy=0, done=0, hi=0, lo=0, div_zero=0 and internal state cleared. A start in the same cycle as reset is ignored.
- The controller must hold the PC clock while busy=1 and use done as the HI/LO write enable.

## Structure
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the FSM state enum;
  - the default WIDTH;
  - the counter width $clog2(WIDTH).
- Sub-module muldiv_iter: purely combinational single radix-2 step, selected by is_div. Inputs: accumulator/remainder, quotient, operand. Outputs: next values. It is instantiated once and used every RUN cycle.
- The FSM, counter, sign fixup and output registers live in muldiv_seq.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF: done in cycle 35 with hi=0xFFFF_FFFE, lo=0x0000_0001; busy high in cycles 1–35.
- MULT −3 × 7: hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000: hi=0x4000_0000, lo=0.
- DIV −7 / 2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 7 / 2: lo=3, hi=1. DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- DIVU 5 / 0: done in cycle 2, div_zero=1, hi=5, lo=0xFFFF_FFFF. A following MULTU 2×3 clears div_zero and gives lo=6, hi=0.
- Start pulses with different operands while busy, including in the DONE cycle: all ignored, and the first op's result is unchanged. A start in cycle 36 is accepted.
- Reset asserted in RUN cycle 10: next cycle busy=0, done=0, hi=lo=0. A fresh DIVU 100/7 then completes in 35 cycles with lo=14, hi=2.
